// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor sequencing logic.
package enigma_pkg;

  localparam int NUM_POS     = 26;
  localparam int NOTCH_R_DEF = 16;  // 'Q'
  localparam int NOTCH_M_DEF = 4;   // 'E'

  typedef logic [4:0] pos_t;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_DEBOUNCE     = 4'd1,
    ST_STEP         = 4'd2,
    ST_ENCODE       = 4'd3,
    ST_WAIT_RELEASE = 4'd4,
    ST_LOAD         = 4'd5
  } state_t;

  // Fold a 5-bit field into 0..NUM_POS-1. Values 26..31 lose 26.
  function automatic pos_t reduce_pos(input pos_t v);
    return (v >= pos_t'(NUM_POS)) ? pos_t'(v - pos_t'(NUM_POS)) : v;
  endfunction

endpackage

// File: rtl/rotor_step_controller_if.sv
// Key/load inputs and rotor status outputs of the rotor step controller.
interface rotor_step_controller_if;
  import enigma_pkg::*;

  logic        key_n;
  logic        load;
  logic [14:0] init_pos;
  pos_t        pos_r;
  pos_t        pos_m;
  pos_t        pos_l;
  logic        step_r;
  logic        step_m;
  logic        step_l;
  logic        encode_strobe;
  logic        busy;
  logic [3:0]  state;

  modport master (
    output key_n, load, init_pos,
    input  pos_r, pos_m, pos_l, step_r, step_m, step_l, encode_strobe, busy, state
  );

  modport slave (
    input  key_n, load, init_pos,
    output pos_r, pos_m, pos_l, step_r, step_m, step_l, encode_strobe, busy, state
  );
endinterface

// File: rtl/mod_counter26.sv
// One rotor position: modulo-26 counter with sync clear, load and increment.
module mod_counter26
  import enigma_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic ld,
  input  pos_t ld_val,
  input  logic inc,
  output pos_t pos
);

  // Clear beats load beats increment; increment wraps 25 -> 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      pos <= '0;
    end else if (ld) begin
      pos <= reduce_pos(ld_val);
    end else if (inc) begin
      pos <= (pos == pos_t'(NUM_POS - 1)) ? '0 : pos + 5'd1;
    end
  end

endmodule

// File: rtl/rotor_step_controller.sv
// Turns a raw keypress into one odometer step of the three-rotor stack,
// including the middle-rotor double-step, then strobes the cipher datapath.
// Optional: define ROTOR_STEP_DEBOUNCE_EN to qualify the key over
// DEBOUNCE_CYCLES stable low cycles; otherwise DEBOUNCE lasts one cycle.
//
// state        | meaning
// IDLE (0)     | waiting for a synchronised press
// DEBOUNCE (1) | qualifying the press
// STEP (2)     | step pulses high, rotors advance at end of cycle
// ENCODE (3)   | positions settled, encode_strobe high
// WAIT_REL (4) | key still held, waiting for release
// LOAD (5)     | positions follow init_pos while load is high
module rotor_step_controller
  import enigma_pkg::*;
#(
  parameter int NOTCH_R         = NOTCH_R_DEF,
  parameter int NOTCH_M         = NOTCH_M_DEF,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  rotor_step_controller_if.slave   bus
);

  state_t state_q, state_d;
  logic   key_s1, key_s2;
  logic   press;

  assign press = ~key_s2;

  // Two-flop synchroniser; idles at released (high).
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= bus.key_n;
      key_s2 <= key_s1;
    end
  end

`ifdef ROTOR_STEP_DEBOUNCE_EN
  // The IDLE cycle that sees the press counts as the first low cycle,
  // so the down-counter covers the remaining DEBOUNCE_CYCLES-1.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 2);

  logic [DB_W-1:0] db_cnt;
  logic            key_prev;

  // Debounce timer: reload on any key change or outside DEBOUNCE.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      db_cnt   <= DB_LOAD;
      key_prev <= 1'b1;
    end else begin
      key_prev <= key_s2;
      if (state_q != ST_DEBOUNCE || key_s2 != key_prev) begin
        db_cnt <= DB_LOAD;
      end else if (db_cnt != '0) begin
        db_cnt <= db_cnt - 1'b1;
      end
    end
  end
`endif

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load overrides every state.
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE:         if (press) state_d = ST_DEBOUNCE;
`ifdef ROTOR_STEP_DEBOUNCE_EN
        ST_DEBOUNCE: begin
          if (!press)              state_d = ST_IDLE;
          else if (db_cnt == '0)   state_d = ST_STEP;
        end
`else
        ST_DEBOUNCE:     state_d = press ? ST_STEP : ST_IDLE;
`endif
        ST_STEP:         state_d = ST_ENCODE;
        ST_ENCODE:       state_d = ST_WAIT_RELEASE;
        ST_WAIT_RELEASE: if (!press) state_d = ST_IDLE;
        ST_LOAD:         state_d = ST_IDLE;
        default:         state_d = ST_IDLE;
      endcase
    end
  end

  // Registered pulses; notch tests see pre-step positions because the
  // counters only move during STEP or LOAD.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      bus.step_r        <= 1'b0;
      bus.step_m        <= 1'b0;
      bus.step_l        <= 1'b0;
      bus.encode_strobe <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      bus.step_r        <= (state_d == ST_STEP);
      bus.step_m        <= (state_d == ST_STEP) &&
                           (bus.pos_r == pos_t'(NOTCH_R) || bus.pos_m == pos_t'(NOTCH_M));
      bus.step_l        <= (state_d == ST_STEP) && (bus.pos_m == pos_t'(NOTCH_M));
      bus.encode_strobe <= (state_d == ST_ENCODE);
      bus.busy          <= (state_d != ST_IDLE) && (state_d != ST_LOAD);
    end
  end

  assign bus.state = state_q;

  logic ld_en;
  assign ld_en = (state_q == ST_LOAD);

  mod_counter26 u_cnt_r (
    .clk    (CLOCK_50),
    .clr    (~resetn),
    .ld     (ld_en),
    .ld_val (bus.init_pos[4:0]),
    .inc    (bus.step_r),
    .pos    (bus.pos_r)
  );

  mod_counter26 u_cnt_m (
    .clk    (CLOCK_50),
    .clr    (~resetn),
    .ld     (ld_en),
    .ld_val (bus.init_pos[9:5]),
    .inc    (bus.step_m),
    .pos    (bus.pos_m)
  );

  mod_counter26 u_cnt_l (
    .clk    (CLOCK_50),
    .clr    (~resetn),
    .ld     (ld_en),
    .ld_val (bus.init_pos[14:10]),
    .inc    (bus.step_l),
    .pos    (bus.pos_l)
  );

endmodule
